// File: rtl/fb_scroll_ctrl.sv
// fb_scroll_ctrl
// ---------------------------------------------------------------------------
// Owns the single-port 8-bit waterfall frame buffer and decides who drives it.
// There are three users:
//   - power-up clear: writes zero to every pixel once after reset
//   - video readout: generates scrolled read addresses during the frame
//   - spectrum line write: during lower blanking, once every 2^SCROLL_DIV_W
//     frames, copies one line of bin magnitudes from the bin BRAM into the
//     current top row, then advances the scroll offset
//
// Optional feature, enabled by defining FB_SCROLL_FREEZE_EN:
//   adds input `freeze`. While it is high, a line write that falls due is
//   skipped. The divider still wraps and y_offset holds. A freeze that rises
//   while a line is already being written does not abort that line.
//
// Ports:
//   clk, reset   pixel clock; synchronous active-high reset
//   x, y         current video column / row
//   visible      video active region
//   lower_blank  vertical blanking after the last visible line
//   bin_addr     bin BRAM read address
//   bin_rd_en    bin BRAM read enable (data valid one cycle later)
//   bin_data     bin BRAM read data
//   line_ack     one-cycle pulse when a full line has been committed
//   fb_addr      frame buffer address
//   fb_wdata     frame buffer write data
//   fb_wen       frame buffer write enable
//   clear_done   sticky flag, set once the initial clear has finished
//   y_offset     current top row index, 0..V_VISIBLE-1
//   state        debug view of the sequencer state (see ST_* below)
//
// Handshake: the bin BRAM is a plain read port. bin_data carries the word for
// the bin_addr that was presented with bin_rd_en=1 on the previous cycle.
// There is no back-pressure. Frame buffer writes are fire-and-forget, one
// per cycle while fb_wen=1.
// ---------------------------------------------------------------------------
module fb_scroll_ctrl #(
  parameter int H_VISIBLE    = 320,
  parameter int V_VISIBLE    = 240,
  parameter int FB_ADDR_W    = 17,
  parameter int BIN_ADDR_W   = 9,
  parameter int DATA_W       = 8,
  parameter int SCROLL_DIV_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            x,
  input  logic [7:0]            y,
  input  logic                  visible,
  input  logic                  lower_blank,
`ifdef FB_SCROLL_FREEZE_EN
  input  logic                  freeze,
`endif
  output logic [BIN_ADDR_W-1:0] bin_addr,
  output logic                  bin_rd_en,
  input  logic [DATA_W-1:0]     bin_data,
  output logic                  line_ack,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [DATA_W-1:0]     fb_wdata,
  output logic                  fb_wen,
  output logic                  clear_done,
  output logic [7:0]            y_offset,
  output logic [1:0]            state
);

  localparam logic [1:0] ST_CLEAR       = 2'd0;
  localparam logic [1:0] ST_VIDEO       = 2'd1;
  localparam logic [1:0] ST_WRITE_LINE  = 2'd2;
  localparam logic [1:0] ST_WAIT_ACTIVE = 2'd3;

  localparam logic [FB_ADDR_W-1:0]  FB_LAST  = FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [FB_ADDR_W-1:0]  H_MULT   = FB_ADDR_W'(H_VISIBLE);
  localparam logic [BIN_ADDR_W-1:0] BIN_LAST = BIN_ADDR_W'(H_VISIBLE - 1);
  localparam logic [8:0]            V_LIMIT  = 9'(V_VISIBLE);
  localparam logic [7:0]            Y_LAST   = 8'(V_VISIBLE - 1);

  // row * H_VISIBLE as a sum of shifted copies of row. H_VISIBLE is constant,
  // so this reduces to a few adders (two for 320 = 256 + 64).
  function automatic logic [FB_ADDR_W-1:0] row_base(input logic [7:0] row);
    logic [FB_ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FB_ADDR_W; i++) begin
      if (H_MULT[i]) acc = acc + (FB_ADDR_W'(row) << i);
    end
    return acc;
  endfunction

  logic [SCROLL_DIV_W-1:0] divider;
  logic                    lb_q;      // lower_blank delayed, for edge detect
  logic                    rd_q;      // bin_rd_en delayed: bin_data valid now
  logic [BIN_ADDR_W-1:0]   addr_q;    // bin_addr delayed, aligned with bin_data
  logic                    wr_last;   // the write on the port is column H-1
  logic                    lb_rise;
  logic                    skip_line;

  logic [8:0]              row_sum;
  logic [8:0]              row_wrap;
  logic [7:0]              vid_row;
  logic [FB_ADDR_W-1:0]    vid_addr;
  logic [FB_ADDR_W-1:0]    line_base;

`ifdef FB_SCROLL_FREEZE_EN
  assign skip_line = freeze;
`else
  assign skip_line = 1'b0;
`endif

  assign lb_rise = lower_blank & ~lb_q;

  // Scrolled readout: display row y shows buffer row (y + y_offset) mod V.
  always_comb begin
    row_sum  = {1'b0, y} + {1'b0, y_offset};
    row_wrap = row_sum - V_LIMIT;
    vid_row  = (row_sum >= V_LIMIT) ? row_wrap[7:0] : row_sum[7:0];
    vid_addr = FB_ADDR_W'(x) + row_base(vid_row);
    line_base = row_base(y_offset);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_wen     <= 1'b0;
      bin_addr   <= '0;
      bin_rd_en  <= 1'b0;
      line_ack   <= 1'b0;
      clear_done <= 1'b0;
      y_offset   <= '0;
      divider    <= '0;
      lb_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wr_last    <= 1'b0;
      state      <= ST_CLEAR;
    end else begin
      lb_q     <= lower_blank;
      line_ack <= 1'b0;
      case (state)
        ST_CLEAR: begin
          fb_wdata <= '0;
          // The first cycle out of reset arms the write at address 0. After
          // that the address steps until the last pixel has been written.
          if (!fb_wen) begin
            fb_wen  <= 1'b1;
            fb_addr <= '0;
          end else if (fb_addr == FB_LAST) begin
            fb_wen     <= 1'b0;
            clear_done <= 1'b1;
            state      <= ST_VIDEO;
          end else begin
            fb_addr <= fb_addr + FB_ADDR_W'(1);
          end
        end

        ST_VIDEO: begin
          fb_wen  <= 1'b0;
          fb_addr <= vid_addr;
          if (lb_rise) begin
            divider <= divider + SCROLL_DIV_W'(1);
            if ((&divider) && !skip_line) begin
              bin_rd_en <= 1'b1;
              bin_addr  <= '0;
              rd_q      <= 1'b0;
              wr_last   <= 1'b0;
              state     <= ST_WRITE_LINE;
            end else begin
              state <= ST_WAIT_ACTIVE;
            end
          end
        end

        ST_WRITE_LINE: begin
          if (fb_wen && wr_last) begin
            // Column H-1 is on the port this cycle, so the line is complete.
            fb_wen    <= 1'b0;
            bin_rd_en <= 1'b0;
            rd_q      <= 1'b0;
            wr_last   <= 1'b0;
            line_ack  <= 1'b1;
            y_offset  <= (y_offset == Y_LAST) ? 8'd0 : y_offset + 8'd1;
            state     <= ST_WAIT_ACTIVE;
          end else if (!lower_blank || visible) begin
            // Blanking ended early. Video owns the port, so drop the partial
            // line without an ack or a scroll step.
            fb_wen    <= 1'b0;
            bin_rd_en <= 1'b0;
            rd_q      <= 1'b0;
            wr_last   <= 1'b0;
            fb_addr   <= vid_addr;
            state     <= ST_VIDEO;
          end else begin
            if (bin_rd_en) begin
              if (bin_addr == BIN_LAST) bin_rd_en <= 1'b0;
              else                      bin_addr  <= bin_addr + BIN_ADDR_W'(1);
            end
            rd_q    <= bin_rd_en;
            addr_q  <= bin_addr;
            fb_wen  <= rd_q;
            wr_last <= rd_q && (addr_q == BIN_LAST);
            if (rd_q) begin
              fb_wdata <= bin_data;
              fb_addr  <= FB_ADDR_W'(addr_q) + line_base;
            end
          end
        end

        ST_WAIT_ACTIVE: begin
          fb_wen  <= 1'b0;
          fb_addr <= vid_addr;
          if (!lower_blank) state <= ST_VIDEO;
        end

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: doc/fb_scroll_ctrl.md
Name: fb_scroll_ctrl

Overview:
- Sequences and arbitrates the single-port 8-bit waterfall frame buffer (H_VISIBLE x V_VISIBLE) between three users: power-up clear, video readout and spectrum line writes.
- During active video it generates scrolled read addresses.
- During lower blanking, every 2^SCROLL_DIV_W frames, it copies one line of frequency-bin magnitudes from the dual-port bin BRAM into the current top row, then advances the scroll offset.
- Sits between video, freq_bram and ram; replaces ad-hoc frame buffer sequencing in the top level.

Parameters:
- H_VISIBLE, 320, pixels per line; also the number of bins copied per line.
- V_VISIBLE, 240, lines per frame.
- FB_ADDR_W, 17, frame buffer address width; must satisfy 2^FB_ADDR_W >= H_VISIBLE*V_VISIBLE.
- BIN_ADDR_W, 9, bin BRAM address width.
- DATA_W, 8, pixel/bin data width.
- SCROLL_DIV_W, 2, width of the frame divider; scroll every 2^SCROLL_DIV_W frames.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- x  in  9  current video column.
- y  in  8  current video row.
- visible  in  1  video active region.
- lower_blank  in  1  high during vertical blanking after the last visible line.
- bin_addr  out  BIN_ADDR_W  bin BRAM read address.
- bin_rd_en  out  1  bin BRAM read enable; read data valid 1 cycle after.
- bin_data  in  DATA_W  bin BRAM read data.
- line_ack  out  1  1-cycle pulse when a full line has been committed.
- fb_addr  out  FB_ADDR_W  frame buffer address.
- fb_wdata  out  DATA_W  frame buffer write data.
- fb_wen  out  1  frame buffer write enable.
- clear_done  out  1  high once the initial clear has completed.
- y_offset  out  8  current top row index, range 0..V_VISIBLE-1.

Behaviour:
- Reset values: fb_addr=0, fb_wdata=0, fb_wen=0, bin_addr=0, bin_rd_en=0, line_ack=0, clear_done=0, y_offset=0, divider=0, state=CLEAR.
- Reset asserted in any state aborts the operation and returns to CLEAR next cycle. There is no partial-write recovery; the buffer is re-cleared.

States:
- CLEAR:
  - fb_wen=1, fb_wdata=0, fb_addr steps 0..H*V-1, one per cycle.
  - Exactly H*V writes, with no write to address H*V.
  - After the last write: fb_wen=0, clear_done=1 (sticky until reset), go to VIDEO.
- VIDEO:
  - Row r = y+y_offset, minus V_VISIBLE if the sum is >= V_VISIBLE, computed from the current y and y_offset.
  - fb_addr <= x + r*H_VISIBLE, registered, 1-cycle latency from x/y. Implement the multiply as shift-add.
  - fb_wen=0.
  - On the cycle lower_blank is first seen high: divider increments.
    - If the divider was all-ones, go to WRITE_LINE.
    - Otherwise go to WAIT_ACTIVE.
- WRITE_LINE:
  - bin_rd_en=1; bin_addr counts 0..H-1.
  - One cycle later: fb_wen=1, fb_wdata=bin_data, fb_addr=(bin_addr delayed 1)+y_offset*H_VISIBLE.
  - Exactly H writes, to columns 0..H-1 of row y_offset.
  - After the write of column H-1:
    - fb_wen=0, bin_rd_en=0, line_ack pulses 1 cycle.
    - y_offset <= y_offset+1, wrapping from V_VISIBLE-1 to 0.
    - Go to WAIT_ACTIVE.
  - Abort: if lower_blank falls before the last write, then next cycle fb_wen=0, bin_rd_en=0, no line_ack, y_offset unchanged, go to VIDEO. Video always wins the port.
- WAIT_ACTIVE:
  - fb_wen=0; stay until lower_blank=0, then go to VIDEO.
- Video priority: fb_wen is never 1 while visible=1.

Optional Feature:
- Macro: FB_SCROLL_FREEZE_EN.
- When defined:
  - Adds input freeze (1 bit).
  - While freeze=1, a WRITE_LINE due at the divider wrap is skipped: go to WAIT_ACTIVE, the divider still wraps, and y_offset holds.
  - A freeze rising mid-WRITE_LINE does not abort the line.
- When undefined: no freeze port, and behaviour is exactly as above.

Test Plan:
- Reset, then run the clock: exactly 76800 cycles with fb_wen=1 and addresses 0..76799 in order, all wdata=0. Then clear_done=1 and fb_wen=0.
- y_offset=239, x=5, y=1: fb_addr=5 one cycle later (row 0). With y_offset=0, x=319, y=239: fb_addr=76799.
- Four lower_blank pulses with SCROLL_DIV_W=2: only the 4th triggers 320 writes to row y_offset, with fb_wdata equal to bin_data of addresses 0..319. Then one line_ack and y_offset+1.
- y_offset=239 and a completed line: y_offset=0, with no write to row 240.
- lower_blank dropped after 100 writes: fb_wen=0 next cycle, no line_ack, y_offset unchanged, and fb_wen=0 whenever visible=1.
- Reset asserted mid-WRITE_LINE: next cycle state is CLEAR, clear_done=0, y_offset=0. With FB_SCROLL_FREEZE_EN and freeze=1 over 8 frames: no writes, y_offset constant.
